// File: rtl/booth_radix4_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, accumulated
// into a 2*WIDTH-bit product, with valid/ready handshakes on both sides.

module booth_radix4_enc (
    input  logic [2:0] i_code,
    output logic       o_zero,
    output logic       o_one,
    output logic       o_two,
    output logic       o_neg1,
    output logic       o_neg2
);

    always_comb begin
        o_zero = 1'b0;
        o_one  = 1'b0;
        o_two  = 1'b0;
        o_neg1 = 1'b0;
        o_neg2 = 1'b0;
        unique case (i_code)
            3'b000, 3'b111: o_zero = 1'b1;
            3'b001, 3'b010: o_one  = 1'b1;
            3'b011:         o_two  = 1'b1;
            3'b100:         o_neg2 = 1'b1;
            default:        o_neg1 = 1'b1;
        endcase
    end

endmodule

module booth_radix4_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_mcand;
    logic [WIDTH:0]  r_mreg;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_product;

    logic            w_zero;
    logic            w_one;
    logic            w_two;
    logic            w_neg1;
    logic            w_neg2;
    logic [PW-1:0]   w_mcand_x2;
    logic [PW-1:0]   w_pp;
    logic [CW:0]     w_shamt;
    logic [PW-1:0]   w_pp_shifted;
    logic [PW-1:0]   w_acc_next;
    logic            w_last;

    booth_radix4_enc u_enc (
        .i_code (r_mreg[2:0]),
        .o_zero (w_zero),
        .o_one  (w_one),
        .o_two  (w_two),
        .o_neg1 (w_neg1),
        .o_neg2 (w_neg2)
    );

    assign w_mcand_x2 = r_mcand << 1;

    // Negation wraps at PW bits; mcand*2 always fits since mcand is only WIDTH significant bits.
    always_comb begin
        w_pp = {PW{1'b0}};
        if (w_zero)
            w_pp = {PW{1'b0}};
        else if (w_one)
            w_pp = r_mcand;
        else if (w_two)
            w_pp = w_mcand_x2;
        else if (w_neg1)
            w_pp = {PW{1'b0}} - r_mcand;
        else if (w_neg2)
            w_pp = {PW{1'b0}} - w_mcand_x2;
    end

    assign w_shamt      = {r_cnt, 1'b0};
    assign w_pp_shifted = w_pp << w_shamt;
    assign w_acc_next   = r_acc + w_pp_shifted;
    assign w_last       = (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mreg    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= {{WIDTH{a[WIDTH-1]}}, a};
                        r_mreg  <= {b, 1'b0};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_mreg <= {{2{r_mreg[WIDTH]}}, r_mreg[WIDTH:2]};
                    r_cnt  <= r_cnt + CW'(1);
                    // Only the finished sum reaches the output register.
                    if (w_last)
                        r_product <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Self-checking bench: directed vectors with literal products plus a queue-based
// signed-product model checked on every cycle, then randomised handshake traffic.

module tb_booth_radix4_seq_mul;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 2;
    localparam int NR    = 2500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] product;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_results = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    bit          prev_ov = 1'b0;
    bit          prev_or = 1'b0;
    logic [31:0] prev_prod = '0;
    bit          rand_done = 1'b0;

    booth_radix4_seq_mul #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_mul(input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Compare process: outputs are stable at the falling edge, so handshakes
    // seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov   = 1'b0;
            prev_or   = 1'b0;
            prev_prod = '0;
        end else begin
            chk("mon_in_ready_vs_busy", 64'(in_ready), 64'(!busy));
            if (prev_ov && !prev_or) begin
                chk("mon_hold_valid", 64'(out_valid), 64'(1));
                chk("mon_hold_product", 64'(product), 64'(prev_prod));
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0)
                    chk("mon_unexpected_valid", 64'(out_valid), 64'(0));
                else
                    chk("mon_latency", 64'(cyc - acc_q[0]), 64'(N));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_mul(a, b));
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("mon_duplicate_result", 64'(1), 64'(0));
                end else begin
                    chk("mon_product", 64'(product), 64'(exp_q.pop_front()));
                    void'(acc_q.pop_front());
                    n_results++;
                end
            end
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_prod = product;
        end
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [31:0] req, input string nm);
        int t;
        int acc_cyc;
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk({nm, "_accept_timeout"}, 64'(t), 64'(0));
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        chk({nm, "_in_ready_drop"}, 64'(in_ready), 64'(0));
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk({nm, "_done_timeout"}, 64'(t), 64'(0));
        chk({nm, "_latency"}, 64'(cyc - acc_cyc), 64'(N));
        chk({nm, "_product"}, 64'(product), 64'(req));
        chk({nm, "_model"}, 64'(model_mul(ta, tbv)), 64'(req));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({nm, "_in_ready_back"}, 64'(in_ready), 64'(1));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int t;
        int base;

        rst_n = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_product", 64'(product), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(16'h0003, 16'h0005, 32'h0000000F, "3x5");
        do_op(16'h8000, 16'h8000, 32'h40000000, "min_x_min");
        do_op(16'hFFFF, 16'h0001, 32'hFFFFFFFF, "m1_x_1");
        do_op(16'h7FFF, 16'h8000, 32'hC0008000, "max_x_min");
        do_op(16'h1234, 16'h5555, 32'h06114F44, "b5555");
        do_op(16'h1234, 16'hAAAA, 32'hF9EE9E88, "bAAAA");
        do_op(16'h1234, 16'hFFFF, 32'hFFFFEDCC, "bFFFF");
        do_op(16'h1234, 16'h0000, 32'h00000000, "b0000");

        // Back-pressure window with ignored in_valid pulses.
        out_ready = 1'b0;
        do_op(16'h0123, 16'hFEDC, 32'hFFFEB414, "bp_op");
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            a = 16'h0055;
            b = 16'h0066;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_product", 64'(product), 64'(32'hFFFEB414));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'(1));
        chk("bp_release_out_valid", 64'(out_valid), 64'(0));

        // Asynchronous reset in the third RUN cycle.
        a = 16'h1234;
        b = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_product", 64'(product), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'h0007, 16'hFFF7, 32'hFFFFFFC1, "7x_m9");

        // Random traffic with gaps on both handshakes.
        base = n_results;
        fork
            begin
                for (int i = 0; i < NR; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    a = 16'($urandom);
                    b = 16'($urandom);
                    if ($urandom_range(0, 15) == 0) a = 16'h8000;
                    if ($urandom_range(0, 15) == 0) b = 16'h8000;
                    in_valid = 1'b1;
                    t = 0;
                    while (!in_ready && t < 100) begin
                        @(posedge clk); #1; t++;
                    end
                    if (t >= 100) chk("rand_accept_timeout", 64'(t), 64'(0));
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("rand_drain", 64'(exp_q.size()), 64'(0));
        chk("rand_result_count", 64'(n_results - base), 64'(NR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
